// File: rtl/escalonador_display_pkg.sv
// Shared encodings for the display scheduler: FSM states, converter source
// select values and the default display dwell.
package escalonador_display_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CARREGA = 2'b01,
    EXIBE   = 2'b10
  } estado_t;

  localparam logic SEL_NUMERO = 1'b0;
  localparam logic SEL_LETRA  = 1'b1;

  localparam int T_EXIBE_PADRAO = 50000;

endpackage

// File: rtl/escalonador_display_contador_m.sv
// Modulo-M up counter used as the display dwell timer; fim flags the
// last count (M-1) so the owner can act on that cycle.
module contador_m #(
  parameter int M = 4,
  parameter int N = 2
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      q <= '0;
    end else if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == N'(M - 1));

endmodule

// File: rtl/escalonador_display.sv
// Round-robin scheduler sharing one 7-segment converter between a number
// requester and a letter requester, holding each grant for T_EXIBE cycles.
module escalonador_display
  import escalonador_display_pkg::*;
#(
  parameter int T_EXIBE = T_EXIBE_PADRAO
) (
  input  logic       clock,
  input  logic       zera_s,
  input  logic       req_numero,
  input  logic [7:0] dado_numero,
  input  logic       req_letra,
  input  logic [4:0] dado_letra,
  output logic       ack_numero,
  output logic       ack_letra,
  output logic       select,
  output logic [7:0] numero,
  output logic [4:0] letra,
  output logic       zera_contador_display,
  output logic       ocupado,
  output logic [1:0] db_estado
);

  localparam int N_CONT = $clog2(T_EXIBE);

  estado_t estado;
  logic    ultimo_grant;
  logic    fim;
  logic    ha_req;
  logic    escolhe_letra;
  logic    inicia_carga;

  // NOTE: combinational logic uses blocking '=' and assigns every output on
  // every pass, so no latch can be inferred.
  always_comb begin
    ha_req        = req_numero | req_letra;
    // Letter wins when it is alone, or on a tie when number was served last.
    escolhe_letra = req_letra & (~req_numero | (ultimo_grant == SEL_NUMERO));
    inicia_carga  = ha_req & ((estado == OCIOSO) | ((estado == EXIBE) & fim));
  end

  contador_m #(
    .M(T_EXIBE),
    .N(N_CONT)
  ) u_temporizador (
    .clock  (clock),
    .zera_as(1'b0),
    .zera_s (zera_s | (estado != EXIBE)),
    .conta  (estado == EXIBE),
    .fim    (fim)
  );

  always_ff @(posedge clock) begin
    if (zera_s) begin
      estado                <= OCIOSO;
      ultimo_grant          <= SEL_LETRA;
      ack_numero            <= 1'b0;
      ack_letra             <= 1'b0;
      select                <= SEL_NUMERO;
      numero                <= '0;
      letra                 <= '0;
      zera_contador_display <= 1'b1;
      ocupado               <= 1'b0;
    end else begin
      ack_numero            <= 1'b0;
      ack_letra             <= 1'b0;
      zera_contador_display <= 1'b0;
      if (inicia_carga) begin
        estado                <= CARREGA;
        ocupado               <= 1'b1;
        zera_contador_display <= 1'b1;
        ultimo_grant          <= escolhe_letra;
        select                <= escolhe_letra;
        if (escolhe_letra) begin
          ack_letra <= 1'b1;
          letra     <= dado_letra;
        end else begin
          ack_numero <= 1'b1;
          numero     <= dado_numero;
        end
      end else begin
        case (estado)
          CARREGA: begin
            estado  <= EXIBE;
            ocupado <= 1'b1;
          end
          EXIBE: begin
            if (fim) begin
              estado  <= OCIOSO;
              ocupado <= 1'b0;
            end
          end
          // Idle with no request, and recovery from the unused encoding.
          default: begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

  assign db_estado = estado;

endmodule
